// File: rtl/switch_pkg.sv
// Shared switch-port definitions: frame marker, FSM state encoding
// and the layout of one port-FIFO entry.
package switch_pkg;

    localparam int DEF_W_WIDTH = 8;
    localparam int LAST_BIT    = DEF_W_WIDTH;

    localparam logic [7:0] SOF_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        SOF,
        ADDR,
        DATA,
        GAP,
        FLUSH
    } state_e;

    function automatic int last_bit_of(input int w);
        return w;
    endfunction

endpackage

// File: rtl/fsm_out_if.sv
// Egress port bundle: FIFO read side, downstream byte stream, control.
interface fsm_out_if #(
    parameter int W_WIDTH = 8
);
    logic               sw_en;
    logic [W_WIDTH-1:0] port_addr;
    logic               fifo_empty;
    logic [W_WIDTH:0]   fifo_rd_data;
    logic               fifo_rd_en;
    logic               port_read;
    logic [W_WIDTH-1:0] data_out;
    logic               out_valid;
    logic               out_frame;
    logic               frame_err;

    modport master (
        input  sw_en,
        input  port_addr,
        input  fifo_empty,
        input  fifo_rd_data,
        input  port_read,
        output fifo_rd_en,
        output data_out,
        output out_valid,
        output out_frame,
        output frame_err
    );

    modport slave (
        output sw_en,
        output port_addr,
        output fifo_empty,
        output fifo_rd_data,
        output port_read,
        input  fifo_rd_en,
        input  data_out,
        input  out_valid,
        input  out_frame,
        input  frame_err
    );

endinterface

// File: rtl/wdog_cnt_out.sv
// Saturating underflow watchdog: counts stalled cycles, flags expiry.
module wdog_cnt_out #(
    parameter int MAX = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int CW = $clog2(MAX + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expire = inc && (cnt_q == CW'(MAX - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CW'(MAX))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fsm_out.sv
// Egress framer: drains the port FIFO and emits SOF, address, payload
// downstream, with backpressure, underflow stall and watchdog abort.
module fsm_out
    import switch_pkg::*;
#(
    parameter int W_WIDTH  = DEF_W_WIDTH,
    parameter int WDOG_MAX = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    fsm_out_if.master bus
);

    localparam int LB = last_bit_of(W_WIDTH);

    state_e             state_q;
    state_e             state_d;
    logic [W_WIDTH-1:0] data_q;
    logic [W_WIDTH-1:0] data_d;
    logic               valid_q;
    logic               valid_d;
    logic               frame_q;
    logic               frame_d;
    logic               err_q;
    logic               err_d;
    logic               last_q;
    logic               last_d;

    logic               rd_en;
    logic               xfer;
    logic               wd_clr;
    logic               wd_inc;
    logic               wd_exp;
    logic [W_WIDTH-1:0] head_byte;
    logic               head_last;

    assign head_byte = bus.fifo_rd_data[W_WIDTH-1:0];
    assign head_last = bus.fifo_rd_data[LB];
    assign xfer      = valid_q && bus.port_read;

    // Stalled only while no byte is pending and nothing can be popped.
    assign wd_inc = (state_q == DATA) && !valid_q && bus.fifo_empty;

    wdog_cnt_out #(
        .MAX(WDOG_MAX)
    ) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (wd_clr),
        .inc   (wd_inc),
        .expire(wd_exp)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        frame_d = frame_q;
        err_d   = 1'b0;
        last_d  = last_q;
        rd_en   = 1'b0;
        wd_clr  = 1'b1;
        unique case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                frame_d = 1'b0;
                if (bus.sw_en && !bus.fifo_empty) begin
                    data_d  = W_WIDTH'(SOF_BYTE);
                    valid_d = 1'b1;
                    frame_d = 1'b1;
                    state_d = SOF;
                end
            end
            SOF: begin
                if (bus.port_read) begin
                    data_d  = bus.port_addr;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (bus.port_read) begin
                    state_d = DATA;
                    if (!bus.fifo_empty) begin
                        rd_en  = 1'b1;
                        data_d = head_byte;
                        last_d = head_last;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            end
            DATA: begin
                wd_clr = 1'b0;
                if (xfer && last_q) begin
                    valid_d = 1'b0;
                    frame_d = 1'b0;
                    wd_clr  = 1'b1;
                    state_d = GAP;
                end else if (xfer || !valid_q) begin
                    if (!bus.fifo_empty) begin
                        rd_en   = 1'b1;
                        data_d  = head_byte;
                        last_d  = head_last;
                        valid_d = 1'b1;
                        wd_clr  = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        if (wd_exp) begin
                            err_d   = 1'b1;
                            frame_d = 1'b0;
                            wd_clr  = 1'b1;
                            state_d = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                valid_d = 1'b0;
                frame_d = 1'b0;
                if (!bus.fifo_empty) begin
                    rd_en = 1'b1;
                    if (head_last) begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                valid_d = 1'b0;
                frame_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            frame_q <= frame_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.data_out   = data_q;
    assign bus.out_valid  = valid_q;
    assign bus.out_frame  = frame_q;
    assign bus.frame_err  = err_q;

endmodule

// File: tb/tb_fsm_out.sv
// Scoreboard bench for the egress framer: queued FIFO model, random
// backpressure/enable, expected byte stream checked by a monitor.
module tb_fsm_out;

    localparam int W      = 8;
    localparam int WDOG   = 16;
    localparam int M_ERR  = 256;
    localparam int M_ADDR = 257;
    localparam int M_SOF  = 258;
    localparam int LASTF  = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    fsm_out_if #(.W_WIDTH(W)) bus ();

    fsm_out #(
        .W_WIDTH (W),
        .WDOG_MAX(WDOG)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int fq[$];
    int push_q[$];
    int exp_q[$];
    int checks = 0;
    int errors = 0;

    bit   mon_en = 1'b0;
    bit   force_rd = 1'b0;
    bit   rand_io = 1'b0;
    bit   clr_req = 1'b0;
    logic rd_val = 1'b1;
    logic sw_val = 1'b1;
    logic [7:0] addr_val = 8'h03;
    logic [7:0] addr_cap = 8'h00;

    logic prev_frame = 1'b0;
    logic sw_prev = 1'b0;
    int   run_len = 0;
    int   inval = 0;
    int   last_run = 0;
    int   last_inval = 0;
    int   runs_done = 0;
    int   err_pulses = 0;

    // Port FIFO model: pops on fifo_rd_en, appends pending pushes.
    always @(posedge clk) begin
        if (clr_req) begin
            fq.delete();
            push_q.delete();
        end else begin
            if (bus.fifo_rd_en && fq.size() > 0) void'(fq.pop_front());
            while (push_q.size() > 0) fq.push_back(push_q.pop_front());
        end
        bus.fifo_empty   <= (fq.size() == 0);
        bus.fifo_rd_data <= (fq.size() > 0) ? 9'(fq[0]) : 9'd0;
    end

    always @(posedge clk) begin
        #1;
        if (force_rd) bus.port_read = 1'b1;
        else if (rand_io) bus.port_read = ($urandom_range(0, 3) != 0);
        else bus.port_read = rd_val;
        if (rand_io) begin
            bus.port_addr = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) bus.sw_en = ~bus.sw_en;
        end else begin
            bus.port_addr = addr_val;
            bus.sw_en = sw_val;
        end
    end

    task automatic sb_check(input int got);
        int e;
        int want;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got %0h, required nothing", got);
            return;
        end
        e = exp_q.pop_front();
        if (e == M_SOF) begin
            want = 8'hFF;
            addr_cap = bus.port_addr;
        end else if (e == M_ADDR) begin
            want = int'(addr_cap);
        end else begin
            want = e;
        end
        if (got != want) begin
            errors++;
            $display("FAIL scoreboard: got %0h, required %0h", got, want);
        end
    endtask

    // Values seen here hold until the next rising edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.fifo_rd_en) begin
                checks++;
                if (bus.fifo_empty) begin
                    errors++;
                    $display("FAIL rd_en_empty: rd_en=1 empty=1, required rd_en=0");
                end
            end
            if (bus.out_frame && !prev_frame) begin
                checks++;
                if (!sw_prev) begin
                    errors++;
                    $display("FAIL sw_en_start: frame began with sw_en=%0b, required 1", sw_prev);
                end
            end
            if (bus.frame_err) begin
                err_pulses++;
                sb_check(bus.out_frame ? M_ERR + 16 : M_ERR);
            end
            if (bus.out_valid && bus.port_read) begin
                if (!bus.out_frame) begin
                    checks++;
                    errors++;
                    $display("FAIL envelope: out_frame=0 on byte %0h, required 1", bus.data_out);
                end
                sb_check(int'(bus.data_out));
            end
        end
        if (bus.out_frame) begin
            run_len++;
            if (!bus.out_valid) inval++;
        end else if (prev_frame) begin
            last_run = run_len;
            last_inval = inval;
            run_len = 0;
            inval = 0;
            runs_done++;
        end
        prev_frame = bus.out_frame;
        sw_prev = bus.sw_en;
    end

    task automatic push_byte(input int v, input int maxgap);
        repeat ($urandom_range(0, maxgap)) @(posedge clk);
        @(posedge clk);
        #1;
        push_q.push_back(v);
    endtask

    task automatic wait_fifo_empty();
        int n = 0;
        while ((fq.size() != 0 || push_q.size() != 0) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL fifo_drain: %0d entries left, required 0", fq.size());
        end
    endtask

    task automatic wait_runs(input int n);
        int c = 0;
        while (runs_done < n && c < 3000) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (c >= 3000) begin
            checks++;
            errors++;
            $display("FAIL frame_end: runs=%0d, required %0d", runs_done, n);
        end
    endtask

    task automatic wait_drain();
        int c = 0;
        while (exp_q.size() != 0 && c < 6000) begin
            @(posedge clk);
            #1;
            c++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d items pending, required 0", exp_q.size());
        end
    endtask

    // mode 0 plain, 1 short underflow after pos bytes, 2 abort after pos bytes
    task automatic send_frame(input int len, input int mode, input int pos);
        int b[$];
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 7) == 0) b.push_back(8'hFF);
            else b.push_back(int'($urandom_range(0, 255)));
        end
        exp_q.push_back(M_SOF);
        exp_q.push_back(M_ADDR);
        for (int i = 0; i < len; i++) begin
            if (mode != 2 || i < pos) exp_q.push_back(b[i]);
        end
        if (mode == 2) exp_q.push_back(M_ERR);
        for (int i = 0; i < len; i++) begin
            if (mode != 0 && i == pos) begin
                wait_fifo_empty();
                if (mode == 1) begin
                    repeat ($urandom_range(1, 6)) @(posedge clk);
                end else begin
                    force_rd = 1'b1;
                    repeat (WDOG + 24) @(posedge clk);
                    force_rd = 1'b0;
                end
            end
            push_byte(b[i] | ((i == len - 1) ? LASTF : 0), 2);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int len;
        int mode;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (bus.data_out !== 8'h00 || bus.out_valid !== 1'b0 ||
            bus.out_frame !== 1'b0 || bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: data=%0h v=%0b f=%0b e=%0b, required all 0",
                     bus.data_out, bus.out_valid, bus.out_frame, bus.frame_err);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);

        // plain three-byte frame with a preloaded FIFO
        #1;
        base = runs_done;
        exp_q.push_back(M_SOF);
        exp_q.push_back(M_ADDR);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        push_q.push_back(8'h11);
        push_q.push_back(8'h22);
        push_q.push_back(LASTF | 8'h33);
        wait_runs(base + 1);
        checks++;
        if (last_run != 5 || last_inval != 0) begin
            errors++;
            $display("FAIL stream_envelope: high=%0d idle=%0d, required 5 and 0",
                     last_run, last_inval);
        end

        // mid-frame underflow shorter than the watchdog limit
        repeat (3) @(posedge clk);
        #1;
        base = runs_done;
        exp_q.push_back(M_SOF);
        exp_q.push_back(M_ADDR);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        push_q.push_back(8'h11);
        wait_fifo_empty();
        repeat (5) @(posedge clk);
        push_byte(8'h22, 0);
        push_byte(LASTF | 8'h33, 0);
        wait_runs(base + 1);
        checks++;
        if (last_inval < 5 || last_run != 5 + last_inval || err_pulses != 0) begin
            errors++;
            $display("FAIL underflow: high=%0d stalled=%0d err=%0d, required high=5+stalled>=10 err=0",
                     last_run, last_inval, err_pulses);
        end

        // watchdog abort, silent flush, clean restart
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(M_SOF);
        exp_q.push_back(M_ADDR);
        exp_q.push_back(8'h11);
        exp_q.push_back(M_ERR);
        push_q.push_back(8'h11);
        wait_fifo_empty();
        force_rd = 1'b1;
        repeat (WDOG + 24) @(posedge clk);
        force_rd = 1'b0;
        push_byte(8'hAA, 0);
        push_byte(LASTF | 8'hBB, 0);
        repeat (8) @(posedge clk);
        exp_q.push_back(M_SOF);
        exp_q.push_back(M_ADDR);
        exp_q.push_back(8'h44);
        push_byte(LASTF | 8'h44, 0);
        wait_drain();
        checks++;
        if (err_pulses != 1) begin
            errors++;
            $display("FAIL abort_pulse: pulses=%0d, required 1", err_pulses);
        end

        // randomized frames, backpressure, enable toggling, stalls, aborts
        rand_io = 1'b1;
        for (int f = 0; f < 50; f++) begin
            len = $urandom_range(1, 6);
            mode = 0;
            if (len >= 2) begin
                case ($urandom_range(0, 5))
                    4: mode = 1;
                    5: mode = 2;
                    default: mode = 0;
                endcase
            end
            send_frame(len, mode, (len >= 2) ? $urandom_range(1, len - 1) : 0);
        end
        rand_io = 1'b0;
        sw_val = 1'b1;
        rd_val = 1'b1;
        wait_drain();

        // asynchronous reset in the middle of a payload
        repeat (6) @(posedge clk);
        #1;
        mon_en = 1'b0;
        push_q.push_back(8'h01);
        push_q.push_back(8'h02);
        push_q.push_back(8'h03);
        push_q.push_back(8'h04);
        push_q.push_back(8'h05);
        push_q.push_back(LASTF | 8'h06);
        begin
            int c = 0;
            while ((fq.size() > 3 || push_q.size() != 0) && c < 200) begin
                @(posedge clk);
                #1;
                c++;
            end
        end
        #2;
        rst_n = 1'b0;
        clr_req = 1'b1;
        #1;
        checks++;
        if (bus.data_out !== 8'h00 || bus.out_valid !== 1'b0 ||
            bus.out_frame !== 1'b0 || bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_frame: data=%0h v=%0b f=%0b e=%0b, required all 0",
                     bus.data_out, bus.out_valid, bus.out_frame, bus.frame_err);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clr_req = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_frame !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: f=%0b v=%0b, required 0 0",
                     bus.out_frame, bus.out_valid);
        end
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        send_frame(3, 0, 0);
        wait_drain();

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
